// File: rtl/xb_dwt_stream.sv
// ----------------------------------------------------------------------------
// xb_dwt_stream -- multi-level streaming discrete wavelet decomposition unit.
//
// Samples are pulled over a read handshake and pushed through a cascade of
// FIR low/high-pass filters with decimation by 2 per level. Only the selected
// level/band is written out, over a back-pressured write handshake. A single
// shared multiplier performs every MAC, one product per cycle.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   xb_en            run enable; low returns to IDLE and clears history
//   read_quit        pause; freezes all state and masks both requests
//   level_sel        output level 1..LEVELS (0 -> 1, >LEVELS -> LEVELS)
//   band_sel         0 = low band, 1 = high band at the output level
//   read_req/read_ready/read_data      sample input handshake
//   write_req/write_ready/write_data   result output handshake
//   coef_l, coef_h   flat coefficient buses, tap t at [t*COEF_W +: COEF_W]
//   busy             high whenever the engine is not in IDLE
//
// Build option:
//   XB_DWT_SAT_EN    when defined, out-of-range results saturate to the
//                    signed DATA_W range; otherwise the low DATA_W bits are
//                    kept (two's-complement wrap).
// ----------------------------------------------------------------------------
module xb_dwt_stream #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int LEVELS = 3,
  parameter int FRAC   = 15,
  parameter int LW     = $clog2(LEVELS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xb_en,
  input  logic                     read_quit,
  input  logic [LW-1:0]            level_sel,
  input  logic                     band_sel,
  output logic                     read_req,
  input  logic                     read_ready,
  input  logic [DATA_W-1:0]        read_data,
  output logic                     write_req,
  input  logic                     write_ready,
  output logic [DATA_W-1:0]        write_data,
  input  logic [TAPS*COEF_W-1:0]   coef_l,
  input  logic [TAPS*COEF_W-1:0]   coef_h,
  output logic                     busy
);

  localparam int TW = $clog2(TAPS + 1);        // tap counter runs 0..TAPS
  localparam int PW = DATA_W + COEF_W;         // product width
  localparam int AW = PW + $clog2(TAPS);       // accumulator width

  typedef enum logic [1:0] {IDLE, READ, MAC, WRITE} state_t;

  state_t              state_q, state_d;
  logic [LEVELS-1:0]   n_q, n_d;
  logic [LW-1:0]       lvl_q, lvl_d;           // 0-based level being filtered
  logic [LW-1:0]       lsel_q, lsel_d;         // latched output level, 1-based
  logic                bsel_q, bsel_d;
  logic [TW-1:0]       tap_q, tap_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                read_req_q, write_req_q, busy_q;
  logic [DATA_W-1:0]   dl_q [LEVELS][TAPS];    // one delay line per level, [0] newest
  logic [DATA_W-1:0]   dl_d [LEVELS][TAPS];

  // ---------------------------------------------------------------- datapath
  int                        ti;
  int                        li;
  logic                      final_lvl;
  logic                      due;
  logic [TAPS*COEF_W-1:0]    coef_sel;
  logic signed [DATA_W-1:0]  x_sel;
  logic signed [COEF_W-1:0]  c_sel;
  logic signed [PW-1:0]      prod;
  logic [AW-1:0]             prod_ext;
  logic [DATA_W-1:0]         res;

`ifdef XB_DWT_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [AW-1:0] sh;
`endif

  always_comb begin
    // The store cycle (tap_q == TAPS) does not use the multiplier, so its
    // index is parked on tap 0 to keep the array selects in range.
    ti        = (tap_q < TW'(TAPS)) ? int'(tap_q) : 0;
    li        = int'(lvl_q);
    final_lvl = ((lvl_q + LW'(1)) == lsel_q);
    // Only the output level can use the high band; cascaded levels are low.
    coef_sel  = (final_lvl && bsel_q) ? coef_h : coef_l;
    x_sel     = $signed(dl_q[li][ti]);
    c_sel     = $signed(coef_sel[ti*COEF_W +: COEF_W]);
    prod      = PW'(x_sel) * PW'(c_sel);
    prod_ext  = {{(AW-PW){prod[PW-1]}}, prod};

    // Level k (1-based) is due when the low k bits of n are all zero.
    due = 1'b1;
    for (int b = 0; b < LEVELS; b++) begin
      if (b <= li && n_q[b]) due = 1'b0;
    end

`ifdef XB_DWT_SAT_EN
    sh = acc_q >>> FRAC;
    if (sh > SAT_MAX)      res = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < SAT_MIN) res = {1'b1, {(DATA_W-1){1'b0}}};
    else                   res = sh[DATA_W-1:0];
`else
    // Arithmetic shift then truncation is exactly this bit slice.
    res = acc_q[FRAC +: DATA_W];
`endif
  end

  // ---------------------------------------------------------- next state
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    lvl_d        = lvl_q;
    lsel_d       = lsel_q;
    bsel_d       = bsel_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    write_data_d = write_data_q;
    dl_d         = dl_q;

    if (!xb_en) begin
      // Disable wins over pause and over any handshake in this cycle.
      state_d = IDLE;
      n_d     = '0;
      lvl_d   = '0;
      tap_d   = '0;
      acc_d   = '0;
      for (int l = 0; l < LEVELS; l++) begin
        for (int t = 0; t < TAPS; t++) dl_d[l][t] = '0;
      end
    end else if (!read_quit) begin
      unique case (state_q)
        IDLE: begin
          if (level_sel == '0)              lsel_d = LW'(1);
          else if (level_sel > LW'(LEVELS)) lsel_d = LW'(LEVELS);
          else                              lsel_d = level_sel;
          bsel_d  = band_sel;
          state_d = READ;
        end
        READ: begin
          if (read_ready) begin
            for (int t = TAPS-1; t > 0; t--) dl_d[0][t] = dl_q[0][t-1];
            dl_d[0][0] = read_data;
            n_d     = n_q + LEVELS'(1);
            lvl_d   = '0;
            tap_d   = '0;
            acc_d   = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          if (tap_q == '0 && !due) begin
            state_d = READ;
          end else if (tap_q < TW'(TAPS)) begin
            acc_d = acc_q + prod_ext;
            tap_d = tap_q + TW'(1);
          end else if (final_lvl) begin
            write_data_d = res;
            state_d      = WRITE;
          end else begin
            // Low band feeds the next level; its due check happens on tap 0.
            for (int l = 1; l < LEVELS; l++) begin
              if (l == li + 1) begin
                for (int t = TAPS-1; t > 0; t--) dl_d[l][t] = dl_q[l][t-1];
                dl_d[l][0] = res;
              end
            end
            lvl_d = lvl_q + LW'(1);
            tap_d = '0;
            acc_d = '0;
          end
        end
        WRITE: begin
          if (write_ready) state_d = READ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      lvl_q        <= '0;
      lsel_q       <= LW'(1);
      bsel_q       <= 1'b0;
      tap_q        <= '0;
      acc_q        <= '0;
      write_data_q <= '0;
      read_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      for (int l = 0; l < LEVELS; l++) begin
        for (int t = 0; t < TAPS; t++) dl_q[l][t] <= '0;
      end
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      lvl_q        <= lvl_d;
      lsel_q       <= lsel_d;
      bsel_q       <= bsel_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      write_data_q <= write_data_d;
      read_req_q   <= (state_d == READ);
      write_req_q  <= (state_d == WRITE);
      busy_q       <= (state_d != IDLE);
      dl_q         <= dl_d;
    end
  end

  // Requests are masked in the same cycle that pause or disable is seen, so
  // a ready arriving then is never mistaken for a completed handshake.
  assign read_req   = read_req_q  & xb_en & ~read_quit;
  assign write_req  = write_req_q & xb_en & ~read_quit;
  assign write_data = write_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_xb_dwt_stream.sv
module tb_xb_dwt_stream;
  localparam int DW     = 16;
  localparam int CW     = 16;
  localparam int TAPS   = 8;
  localparam int LEVELS = 3;
  localparam int LW     = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               xb_en;
  logic               read_quit;
  logic [LW-1:0]      level_sel;
  logic               band_sel;
  logic               read_req;
  logic               read_ready;
  logic [DW-1:0]      read_data;
  logic               write_req;
  logic               write_ready;
  logic [DW-1:0]      write_data;
  logic [TAPS*CW-1:0] coef_l;
  logic [TAPS*CW-1:0] coef_h;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int lat;

  always #5 clk = ~clk;

  xb_dwt_stream #(
    .DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .LEVELS(LEVELS), .FRAC(15)
  ) dut (
    .clk(clk), .reset(reset), .xb_en(xb_en), .read_quit(read_quit),
    .level_sel(level_sel), .band_sel(band_sel),
    .read_req(read_req), .read_ready(read_ready), .read_data(read_data),
    .write_req(write_req), .write_ready(write_ready), .write_data(write_data),
    .coef_l(coef_l), .coef_h(coef_h), .busy(busy)
  );

  always @(posedge clk) if (write_req && write_ready) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reconfigure with the engine disabled (clears history), then enable.
  task automatic start(input logic [LW-1:0] lsel, input logic bsel,
                       input logic [CW-1:0] l0, input logic [CW-1:0] l1, input logic [CW-1:0] l2,
                       input logic [CW-1:0] h0, input logic [CW-1:0] h1);
    @(negedge clk); xb_en = 1'b0;
    @(negedge clk);
    coef_l = '0; coef_h = '0;
    coef_l[0*CW +: CW] = l0; coef_l[1*CW +: CW] = l1; coef_l[2*CW +: CW] = l2;
    coef_h[0*CW +: CW] = h0; coef_h[1*CW +: CW] = h1;
    level_sel = lsel; band_sel = bsel;
    @(negedge clk); xb_en = 1'b1;
  endtask

  task automatic feed(input logic [DW-1:0] v);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (read_req) break;
    end
    if (!read_req) begin
      chk("feed_timeout", 32'd0, 32'd1);
      return;
    end
    read_data = v; read_ready = 1'b1;
    @(posedge clk); #1 read_ready = 1'b0;
    $display("read  data=%0d", $signed(v));
  endtask

  task automatic get_write(input string tag, input logic [DW-1:0] exp, input int stall,
                           output int latency);
    latency = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); latency++;
      if (write_req) break;
    end
    if (!write_req) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk(tag, 32'(write_data), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {15'd0, write_req, write_data}, {15'd0, 1'b1, exp});
    end
    write_ready = 1'b1;
    @(posedge clk); #1 write_ready = 1'b0;
    $display("write %s data=0x%0h expected=0x%0h", tag, write_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b0; xb_en = 1'b0; read_quit = 1'b0; level_sel = '0; band_sel = 1'b0;
    read_ready = 1'b0; read_data = '0; write_ready = 1'b0; coef_l = '0; coef_h = '0;
    repeat (3) @(negedge clk);
    chk("rst_read_req",   32'(read_req),   32'd0);
    chk("rst_write_req",  32'(write_req),  32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    reset = 1'b1;

    // Level 1 low band: (100+200)/2 after the second sample only.
    start(2'd1, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    feed(16'd100);
    chk("l1_busy", 32'(busy), 32'd1);
    feed(16'd200);
    chk("l1_nowrite_early", 32'(wr_cnt), 32'd0);
    get_write("l1_low", 16'd150, 0, lat);
    chk("l1_latency", 32'(lat), 32'(TAPS + 2));
    chk("l1_wr_cnt", 32'(wr_cnt), 32'd1);

    // Level 1 high band: 0.5*200 - 0.5*100.
    start(2'd1, 1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h4000, 16'hC000);
    feed(16'd100);
    feed(16'd200);
    get_write("l1_high", 16'd50, 0, lat);

    // Level 2 cascade: L1 gives 150, 350; L2 gives (350+150)/2.
    start(2'd2, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    base = wr_cnt;
    feed(16'd100); feed(16'd200); feed(16'd300); feed(16'd400);
    chk("l2_nowrite_early", 32'(wr_cnt), 32'(base));
    get_write("l2_low", 16'd250, 0, lat);
    chk("l2_wr_cnt", 32'(wr_cnt), 32'(base + 1));

    // Accumulator width: 2*0x7FFF*0x7FFF >> 15 = 0xFFFC (wrap) or 0x7FFF (sat).
    start(2'd1, 1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    feed(16'h7FFF); feed(16'h7FFF);
`ifdef XB_DWT_SAT_EN
    get_write("width_sat", 16'h7FFF, 0, lat);
`else
    get_write("width_wrap", 16'hFFFC, 0, lat);
`endif

    // Back-pressure then pause in READ, with a stray read_ready while paused.
    start(2'd1, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    feed(16'd10); feed(16'd20);
    get_write("bp_w1", 16'd15, 5, lat);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (read_req) break;
    end
    read_quit = 1'b1; read_ready = 1'b1; read_data = 16'd999;
    for (int i = 0; i < 3; i++) begin
      #1 chk("pause_read_req", 32'(read_req), 32'd0);
      @(negedge clk);
    end
    chk("pause_busy", 32'(busy), 32'd1);
    read_quit = 1'b0; read_ready = 1'b0;
    feed(16'd30); feed(16'd40);
    get_write("bp_w2", 16'd35, 0, lat);

    // Restart mid-MAC with a third tap so stale history would show up.
    start(2'd1, 1'b0, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h0000);
    feed(16'd100); feed(16'd200);
    repeat (3) @(negedge clk);
    xb_en = 1'b0;
    @(negedge clk);
    chk("restart_busy",       32'(busy),       32'd0);
    chk("restart_write_req",  32'(write_req),  32'd0);
    chk("restart_write_data", 32'(write_data), 32'd35);
    xb_en = 1'b1;
    feed(16'd60); feed(16'd80);
    get_write("restart_fresh", 16'd70, 0, lat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/xb_dwt_stream.md
# xb_dwt_stream

- Parametrised successor to the fixed 3-level wavelet (xb) engine: a multi-level streaming discrete wavelet decomposition unit.
- Pulls samples over a read handshake, cascades FIR low/high-pass filtering with decimation-by-2 per level, and writes the selected level/band output over a back-pressured write handshake.
- Coefficients come from the xb coefficient register file as flat buses; one shared multiplier performs the MACs sequentially.

## Interface
- DATA_W, 16, sample and output width, signed
- COEF_W, 16, coefficient width, signed Q1.(COEF_W-1)
- TAPS, 8, filter length per band, ≥2
- LEVELS, 3, maximum decomposition depth, ≥1
- FRAC, 15, right shift applied to the accumulator
- LW, $clog2(LEVELS+1), width of level_sel
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- xb_en  in  1  run enable; low returns to IDLE and clears history
- read_quit  in  1  pause; freezes state, deasserts requests
- level_sel  in  LW  level to output, 1..LEVELS
- band_sel  in  1  0 = low band, 1 = high band
- read_req  out  1  sample request
- read_ready  in  1  read_data valid; completes the read
- read_data  in  DATA_W  input sample
- write_req  out  1  output valid
- write_ready  in  1  sink accepts write_data
- write_data  out  DATA_W  filtered output
- coef_l  in  TAPS*COEF_W  low-pass coefficients; tap t at [t*COEF_W +: COEF_W]
- coef_h  in  TAPS*COEF_W  high-pass coefficients, same packing
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, READ, MAC, WRITE.
- IDLE:
  - When xb_en=1 and read_quit=0, latch level_sel/band_sel (Lsel, Bsel) and go to READ.
  - level_sel=0 is treated as 1; values >LEVELS are clamped to LEVELS.
- READ:
  - read_req=1 until a cycle with read_ready=1.
  - On that cycle, shift read_data into the level-1 delay line (x[0] = newest) and increment the sample count n. n has LEVELS bits and wraps.
  - Go to MAC.
- MAC:
  - Level k is due when n mod 2^k = 0. Process levels k = 1..Lsel in order and stop at the first level that is not due; if none is due, return to READ.
  - For k<Lsel: compute the low band and shift the result into the level-(k+1) delay line.
  - For k=Lsel: compute the band selected by Bsel, hold it in write_data, and go to WRITE.
  - Levels above Lsel are never computed.
- Filter: y = Σ_{t=0}^{TAPS-1} c[t]·x[t].
  - One product per cycle.
  - Accumulator width: DATA_W+COEF_W+$clog2(TAPS).
  - Result = acc >>> FRAC (arithmetic shift, truncating), reduced to DATA_W per Configuration.
- WRITE: write_req=1 with write_data stable until a cycle with write_ready=1; next state READ.
- read_quit=1 (with xb_en=1): read_req and write_req are forced to 0; state, MAC progress, write_data and history are frozen; operation resumes where it stopped.
- xb_en=0: next state IDLE, all delay lines and n cleared, requests 0; write_data is retained.
- Delay lines start at zero, so initial outputs include zero history.
- Coefficients are read live during MAC; software changes them only while xb_en=0.

## Timing
- Reset values: read_req=0, write_req=0, write_data=0, busy=0, state IDLE, n=0, delay lines 0.
- A read completes in the read_ready cycle; MAC starts the next cycle.
- Each band computation takes TAPS+1 cycles (TAPS MAC cycles plus 1 scale/store cycle).
- write_req rises the cycle after the last band finishes.
- After the write_ready cycle, read_req rises the next cycle.
- read_ready or write_ready arriving while the matching request is low is ignored.
- Simultaneous xb_en fall and a read_ready/write_ready cycle: the handshake is discarded; xb_en takes priority over read_quit.
- Output rate: one write per 2^Lsel samples.

## Configuration
- XB_DWT_SAT_EN defined: results outside the signed DATA_W range saturate to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
- XB_DWT_SAT_EN undefined: the low DATA_W bits are kept (two's-complement wrap).

## Test plan
- Level 1, low band: Lsel=1, Bsel=0, coef_l t0=t1=0x4000, other taps 0; inputs 100, 200 → no write after sample 1; after sample 2, one write of 150.
- Level 1, high band: same setup with Bsel=1, coef_h t0=0x4000, t1=0xC000; inputs 100, 200 → write 50.
- Level 2 cascade: Lsel=2, low band, coefficients as in the low-band test; inputs 100, 200, 300, 400 → exactly one write, 250, after sample 4.
- Arithmetic width: coef_l t0=t1=0x7FFF, inputs 0x7FFF, 0x7FFF, Lsel=1 → 0x7FFF with XB_DWT_SAT_EN, 0xFFFC without.
- Pause and back-pressure: hold write_ready=0 for 5 cycles, then assert read_quit during READ for 3 cycles → write_data stable, read_req low during the pause, no sample lost, outputs match an uninterrupted run.
- Restart: drop xb_en mid-MAC, then re-enable → busy=0 next cycle; the following outputs match a fresh run from reset.
